// File: rtl/save_ctrl_unit_if.sv
// Bus between the save controller, the IC wrappers and the retention memory port.
// master = controller side, slave = wrapper/memory/power-controller side.
interface save_ctrl_unit_if #(
  parameter int unsigned N = 10,
  parameter int unsigned K = 32,
  parameter int unsigned M = 32
);
  logic         start;
  logic [K-1:0] base_addr;
  logic [M-1:0] save_val;
  logic         ack_mem;
  logic [N-1:0] save_en;
  logic         write_mem;
  logic [K-1:0] addr_mem;
  logic [M-1:0] data_mem;
  logic         busy;
  logic         done;

  modport master (
    input  start, base_addr, save_val, ack_mem,
    output save_en, write_mem, addr_mem, data_mem, busy, done
  );

  modport slave (
    output start, base_addr, save_val, ack_mem,
    input  save_en, write_mem, addr_mem, data_mem, busy, done
  );
endinterface

// File: rtl/save_ctrl_unit.sv
// Save control unit: walks N IC wrappers in index order, captures each value and
// writes it to retention memory at base+index with a request/acknowledge handshake.
module save_ctrl_unit #(
  parameter int unsigned N = 10,
  parameter int unsigned K = 32,
  parameter int unsigned M = 32
) (
  input  logic              clk,
  input  logic              rst,
  save_ctrl_unit_if.master  bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [K-1:0]  base_q, base_d;
  logic [M-1:0]  data_q, data_d;

  logic [N-1:0]  save_en_d;
  logic          write_mem_d;
  logic [K-1:0]  addr_mem_d;
  logic [M-1:0]  data_mem_d;
  logic          busy_d;
  logic          done_d;

  // State, datapath and output registers; reset abandons any save in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      base_q        <= '0;
      data_q        <= '0;
      bus.save_en   <= '0;
      bus.write_mem <= 1'b0;
      bus.addr_mem  <= '0;
      bus.data_mem  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      data_q        <= data_d;
      bus.save_en   <= save_en_d;
      bus.write_mem <= write_mem_d;
      bus.addr_mem  <= addr_mem_d;
      bus.data_mem  <= data_mem_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d  = bus.base_addr;
          idx_d   = '0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        data_d  = bus.save_val;
        state_d = S_WR;
      end
      S_WR: begin
        if (bus.ack_mem) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SEL;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    save_en_d   = '0;
    write_mem_d = 1'b0;
    addr_mem_d  = '0;
    data_mem_d  = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_SEL: begin
        save_en_d = N'(1) << idx_d;
        busy_d    = 1'b1;
      end
      S_WR: begin
        write_mem_d = 1'b1;
        addr_mem_d  = base_d + K'(idx_d);
        data_mem_d  = data_d;
        busy_d      = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_save_ctrl_unit.sv
// Directed bench for save_ctrl_unit: an N=4 instance driven from a vector table plus
// hand sequences, and an N=1 instance for the single-wrapper case.
module tb_save_ctrl_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  save_ctrl_unit_if #(.N(4), .K(32), .M(32)) bus0 ();
  save_ctrl_unit_if #(.N(1), .K(32), .M(32)) bus1 ();

  save_ctrl_unit #(.N(4), .K(32), .M(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  save_ctrl_unit #(.N(1), .K(32), .M(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrapper model: selected wrapper i returns 0xA0 + i.
  always_comb begin
    bus0.save_val = '0;
    for (int i = 0; i < 4; i++)
      if (bus0.save_en[i]) bus0.save_val = 32'hA0 + 32'(i);
  end

  assign bus1.save_val = 32'hDEAD_BEEF;

  typedef struct {
    logic        start;
    logic [31:0] base;
    logic        ack;
    logic [3:0]  en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk0(input string name, input logic [3:0] en, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic busy, input logic done);
    chk({name, ".save_en"},   64'(bus0.save_en),   64'(en));
    chk({name, ".write_mem"}, 64'(bus0.write_mem), 64'(wr));
    chk({name, ".addr_mem"},  64'(bus0.addr_mem),  64'(addr));
    chk({name, ".data_mem"},  64'(bus0.data_mem),  64'(data));
    chk({name, ".busy"},      64'(bus0.busy),      64'(busy));
    chk({name, ".done"},      64'(bus0.done),      64'(done));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete zero-wait save on N=4; optional re-Start/base change at poke cycle.
  function automatic void add_save(input logic [31:0] base, input int poke, input logic [31:0] poke_base);
    for (int c = 0; c < 10; c++) begin
      vec_t v;
      v.start = (c == 0) || (c == poke);
      v.base  = (poke >= 0 && c >= poke) ? poke_base : base;
      v.ack   = 1'b1;
      v.en    = '0;
      v.wr    = 1'b0;
      v.addr  = '0;
      v.data  = '0;
      v.busy  = 1'b0;
      v.done  = 1'b0;
      if (c < 8 && (c % 2) == 0) begin
        v.en   = 4'b0001 << (c / 2);
        v.busy = 1'b1;
      end else if (c < 8) begin
        v.wr   = 1'b1;
        v.addr = base + 32'(c / 2);
        v.data = 32'hA0 + 32'(c / 2);
        v.busy = 1'b1;
      end else if (c == 8) begin
        v.done = 1'b1;
        v.busy = 1'b1;
      end
      vecs.push_back(v);
    end
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.start = 1'b0; bus0.base_addr = '0; bus0.ack_mem = 1'b0;
    bus1.start = 1'b0; bus1.base_addr = '0; bus1.ack_mem = 1'b0;

    add_save(32'h0000_0100, -1, 32'h0);
    add_save(32'hFFFF_FFFE, -1, 32'h0);
    add_save(32'h0000_0100, 4, 32'h0000_0200);

    // Reset state
    #12;
    chk0("reset", 4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset.n1_busy", 64'(bus1.busy), 64'h0);
    chk("reset.n1_save_en", 64'(bus1.save_en), 64'h0);
    #4 rst = 1'b0;
    tick;
    chk0("idle_no_start", 4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Table: zero-wait save, address wrap, ignored Start/base change
    foreach (vecs[i]) begin
      bus0.start     = vecs[i].start;
      bus0.base_addr = vecs[i].base;
      bus0.ack_mem   = vecs[i].ack;
      tick;
      chk0($sformatf("vec%0d", i), vecs[i].en, vecs[i].wr, vecs[i].addr,
           vecs[i].data, vecs[i].busy, vecs[i].done);
    end

    // Ack delayed 3 cycles per write: each request held for 4 cycles, done in cycle 21
    bus0.start = 1'b1; bus0.base_addr = 32'h0000_0300; bus0.ack_mem = 1'b0;
    tick;
    bus0.start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      chk0($sformatf("dly_sel%0d", w), 4'b0001 << w, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      bus0.ack_mem = 1'b1;
      tick;
      for (int k = 0; k < 4; k++) begin
        chk0($sformatf("dly_wr%0d_%0d", w, k), 4'b0, 1'b1, 32'h300 + 32'(w),
             32'hA0 + 32'(w), 1'b1, 1'b0);
        bus0.ack_mem = (k == 3);
        tick;
      end
    end
    chk0("dly_done", 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    bus0.ack_mem = 1'b0;
    tick;
    chk0("dly_idle", 4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // N=1: single SEL/WR pass then DONE
    bus1.start = 1'b1; bus1.base_addr = 32'h40; bus1.ack_mem = 1'b1;
    tick;
    bus1.start = 1'b0;
    chk("n1_sel.save_en", 64'(bus1.save_en), 64'h1);
    chk("n1_sel.write_mem", 64'(bus1.write_mem), 64'h0);
    tick;
    chk("n1_wr.save_en", 64'(bus1.save_en), 64'h0);
    chk("n1_wr.write_mem", 64'(bus1.write_mem), 64'h1);
    chk("n1_wr.addr_mem", 64'(bus1.addr_mem), 64'h40);
    chk("n1_wr.data_mem", 64'(bus1.data_mem), 64'hDEAD_BEEF);
    tick;
    chk("n1_done.done", 64'(bus1.done), 64'h1);
    chk("n1_done.write_mem", 64'(bus1.write_mem), 64'h0);
    tick;
    chk("n1_idle.done", 64'(bus1.done), 64'h0);
    chk("n1_idle.busy", 64'(bus1.busy), 64'h0);

    // Asynchronous reset while in WR for idx 2
    bus0.start = 1'b1; bus0.base_addr = 32'h0000_0100; bus0.ack_mem = 1'b1;
    tick;
    bus0.start = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    chk0("pre_rst_wr2", 4'b0, 1'b1, 32'h102, 32'hA2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk0("rst_async", 4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick;
    #3 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk0($sformatf("post_rst%0d", c), 4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    bus0.start = 1'b1; bus0.base_addr = 32'h0000_0500;
    tick;
    bus0.start = 1'b0;
    chk0("restart_sel0", 4'b0001, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick;
    chk0("restart_wr0", 4'b0, 1'b1, 32'h500, 32'hA0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/save_ctrl_unit.md
Name: save_ctrl_unit

Overview:
- Save Control Unit: the write-side counterpart of the restore controller.
- On Start, walks N IC wrappers in index order 0..N-1. For each wrapper it selects the wrapper, captures its M-bit value and writes it to memory at BaseAddr+index with a request/acknowledge handshake.
- Sits between the power controller (Start/Done) and the retention memory port. Done tells the power controller that state is saved and power-off may proceed.

Parameters:
- N, 10, number of IC wrappers to save
- K, 32, width of base/memory address
- M, 32, width of each IC wrapper value

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  reset, asynchronous, active-high
- Start  input  1  save request, sampled in IDLE only
- BaseAddr  input  K  base address of save area, latched on accepted Start
- SaveVal  input  M  value of the currently selected wrapper, driven by the wrappers
- AckMem  input  1  memory write acknowledge, honoured in WR only
- SaveEn  output  N  one-hot wrapper select
- WriteMem  output  1  memory write request
- AddrMem  output  K  memory write address
- DataMem  output  M  memory write data
- Busy  output  1  high in SEL, WR and DONE
- Done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE, idx=0, base_q=0, data_q=0. All outputs 0 (SaveEn, WriteMem, AddrMem, DataMem, Busy, Done). Reset takes effect immediately and asynchronously, including mid-operation. A partial save is abandoned with no further writes. After release, a new Start is required.
- idx width is max(1, clog2(N)). AddrMem = base_q + zero-extended idx, computed modulo 2^K (carry out dropped).
- FSM, one transition per rising edge:
  - IDLE: all outputs 0. If Start=1: latch base_q<=BaseAddr, idx<=0, go to SEL.
  - SEL: SaveEn=onehot(idx), Busy=1, WriteMem=0. At the clock edge, data_q<=SaveVal, then go to WR. SaveVal must be valid during this cycle.
  - WR: WriteMem=1, AddrMem=base_q+idx, DataMem=data_q, SaveEn=0, Busy=1. AddrMem and DataMem are held stable until acknowledged.
    - AckMem=0: stay in WR.
    - AckMem=1 and idx==N-1: go to DONE.
    - AckMem=1 and idx<N-1: idx<=idx+1, go to SEL.
  - DONE: Done=1, Busy=1, WriteMem=0. Next state is IDLE unconditionally.
- Outside WR, AddrMem and DataMem are 0.
- Start is ignored in every state except IDLE. A Start held high through DONE→IDLE starts a new save one cycle after returning to IDLE.
- AckMem is ignored outside WR. An AckMem asserted in the same cycle WriteMem first rises is valid (zero-wait acknowledge).
- Latency with zero-wait ack: Start sampled at edge 0 gives SEL for idx 0 in cycle 1. Each wrapper costs 2 cycles (SEL+WR). Done is high in cycle 2N+1. Each extra wait cycle on AckMem adds one cycle.
- Exactly N writes are issued per save, each acknowledged before the next wrapper is selected. SaveEn is never asserted while WriteMem=1.
- N=1: a single SEL/WR pass, then DONE.

Test Plan:
- N=4, BaseAddr=0x100, wrappers return 0xA0,0xA1,0xA2,0xA3, AckMem tied 1 → writes (0x100,0xA0),(0x101,0xA1),(0x102,0xA2),(0x103,0xA3). SaveEn sequence 0001,0010,0100,1000. Done pulse in cycle 9 after Start, then IDLE.
- Ack delayed 3 cycles per write → WriteMem, AddrMem and DataMem held constant for 4 cycles each. Still exactly 4 writes; Done at cycle 21.
- BaseAddr=0xFFFF_FFFE, N=4 → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- Start pulsed again during WR of idx 1, and BaseAddr changed to 0x200 mid-save → ignored. Addresses continue from 0x100, and only one Done is produced.
- Rst asserted asynchronously mid-cycle while in WR for idx 2 → outputs drop to 0 without waiting for a clock edge, no further writes occur, and the unit stays IDLE until the next Start.
- N=1, BaseAddr=0x40, SaveVal=0xDEAD_BEEF → one write (0x40, 0xDEADBEEF), then Done; SaveEn=1 for one cycle.
